// File: rtl/bawsss_uart_pkg.sv
// -----------------------------------------------------------------------------
// bawsss_uart_pkg
// Shared types and constants for the memory-mapped UART transmitter.
//   uart_state_t : serialiser FSM states
//   STAT_*       : bit positions inside the 16-bit status word
// -----------------------------------------------------------------------------
package bawsss_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/bawsss_byte_fifo.sv
// -----------------------------------------------------------------------------
// bawsss_byte_fifo
// Synchronous byte FIFO with a combinational head read.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset, empties the FIFO
//   push      : write request for push_data
//   push_data : byte to enqueue
//   pop       : remove the head entry (ignored when empty)
//   head      : current head entry, valid while empty=0
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries
// A push while full is still accepted if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module bawsss_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Status flags come straight from the registered occupancy count.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr];

    // When full, the slot being written is the one the pop frees, so the
    // head is read out before it is overwritten at the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array has no reset; contents are only observed through head
    // while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/bawsss_uart_tx.sv
// -----------------------------------------------------------------------------
// bawsss_uart_tx
// Memory-mapped 8N1 UART transmitter on the CPU data-store bus.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset; aborts any frame in flight
//   memWrite   : CPU store strobe
//   address    : CPU data address
//   writeData  : CPU store data (low byte enqueued on DATA_ADDR stores)
//   statusData : {12'b0, overflow, full, empty, busy}
//   tx         : registered serial line, idles high
//   busy       : FSM active or bytes still queued
// Stores to STATUS_ADDR with writeData[0]=1 clear the sticky overflow flag.
// -----------------------------------------------------------------------------
module bawsss_uart_tx
    import bawsss_uart_pkg::*;
#(
    parameter logic [15:0] DATA_ADDR    = 16'hFF00,
    parameter logic [15:0] STATUS_ADDR  = 16'hFF02,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWrite,
    input  logic [15:0] address,
    input  logic [15:0] writeData,
    output logic [15:0] statusData,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    uart_state_t   state_next;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tx_next;
    logic          overflow;

    logic          data_store;
    logic          clear_store;
    logic          refused;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic          unused_high_byte;

    assign data_store       = memWrite && (address == DATA_ADDR);
    assign clear_store      = memWrite && (address == STATUS_ADDR) && writeData[0];
    assign refused          = data_store && fifo_full && !fifo_pop;
    assign unused_high_byte = ^writeData[15:8];

    bawsss_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_store),
        .push_data (writeData[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    // Sticky overflow: a refused push in the same cycle as a clear leaves
    // the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (refused) begin
            overflow <= 1'b1;
        end else if (clear_store) begin
            overflow <= 1'b0;
        end
    end

    // Serialiser state registers. tx is registered from the next-state
    // decode so the line changes on the same edge the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // Next-state decode. The last STOP cycle chains straight into START
    // when another byte is waiting so frames stay back to back.
    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        shift_next = shift;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, LSB first during DATA.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Status word assembled from registered state only.
    always_comb begin
        busy                   = (state != IDLE) || !fifo_empty;
        statusData             = '0;
        statusData[STAT_BUSY]  = busy;
        statusData[STAT_EMPTY] = fifo_empty;
        statusData[STAT_FULL]  = fifo_full;
        statusData[STAT_OVF]   = overflow;
    end

endmodule

// File: tb/tb_bawsss_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_bawsss_uart_tx
// Directed bench for bawsss_uart_tx with CLKS_PER_BIT=4 and an 8-deep FIFO.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, so every sample sees the state left by the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_bawsss_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        rst;
    logic        memWrite;
    logic [15:0] address;
    logic [15:0] writeData;
    logic [15:0] statusData;
    logic        tx;
    logic        busy;

    int checks;
    int failures;

    bawsss_uart_tx #(
        .DATA_ADDR    (16'hFF00),
        .STATUS_ADDR  (16'hFF02),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .statusData (statusData),
        .tx         (tx),
        .busy       (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level at frame slot k: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Puts a store (or an idle bus) on the inputs for the next rising edge.
    task automatic drive(input logic we, input logic [15:0] addr, input logic [15:0] data);
        memWrite  = we;
        address   = addr;
        writeData = data;
    endtask

    // Reset, then 50 idle cycles: line high, only empty set in status.
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || statusData !== 16'h0002) begin
            failures++;
            $display("[TB] FAIL reset_in tx=%b status=%h expected tx=1 status=0002", tx, statusData);
        end
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || statusData !== 16'h0002 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle tx=%b status=%h busy=%b expected 1/0002/0", tx, statusData, busy);
        end
    endtask

    // One byte 16'h12A5: the upper byte must be ignored and the line must
    // carry 0,1,0,1,0,0,1,0,1,1 with each slot held CPB cycles.
    task automatic test_single_frame();
        for (int c = 0; c <= FRAME + 2; c++) begin
            if (c == 1) begin
                checks++;
                if (tx !== 1'b1 || busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL single_push_edge tx=%b busy=%b expected tx=1 busy=1", tx, busy);
                end
            end
            if (c >= 2 && c - 2 < FRAME) begin
                checks++;
                if (tx !== frame_bit(8'hA5, (c - 2) / CPB)) begin
                    failures++;
                    $display("[TB] FAIL single_tx s=%0d got=%b expected=%b", c - 2, tx, frame_bit(8'hA5, (c - 2) / CPB));
                end
            end
            if (c - 2 == FRAME - 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL single_busy_stop got=%b expected=1", busy);
                end
            end
            if (c - 2 == FRAME) begin
                checks++;
                if (busy !== 1'b0 || tx !== 1'b1 || statusData !== 16'h0002) begin
                    failures++;
                    $display("[TB] FAIL single_done busy=%b tx=%b status=%h expected 0/1/0002", busy, tx, statusData);
                end
            end
            if (c == 0) drive(1'b1, 16'hFF00, 16'h12A5);
            else        drive(1'b0, 16'hFF00, 16'h0000);
            @(negedge clk);
        end
    endtask

    // Three stores on consecutive edges must give three frames with no gap.
    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h41;
        bytes[1] = 8'h42;
        bytes[2] = 8'h43;
        for (int c = 0; c <= 3 * FRAME + 2; c++) begin
            if (c >= 2 && c - 2 < 3 * FRAME) begin
                checks++;
                if (tx !== frame_bit(bytes[(c - 2) / FRAME], ((c - 2) % FRAME) / CPB)) begin
                    failures++;
                    $display("[TB] FAIL b2b_tx s=%0d got=%b expected=%b", c - 2, tx,
                             frame_bit(bytes[(c - 2) / FRAME], ((c - 2) % FRAME) / CPB));
                end
            end
            if (c - 2 == 3 * FRAME) begin
                checks++;
                if (busy !== 1'b0 || tx !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_done busy=%b tx=%b expected 0/1", busy, tx);
                end
            end
            if (c < 3) drive(1'b1, 16'hFF00, {8'h00, bytes[c]});
            else       drive(1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
        end
    endtask

    // Ten stores on consecutive edges: one popped at once, eight queued,
    // the tenth dropped with overflow set; then a clear store.
    task automatic test_overflow();
        for (int c = 0; c <= 9 * FRAME + 2; c++) begin
            if (c == 10) begin
                checks++;
                if (statusData !== 16'h000D) begin
                    failures++;
                    $display("[TB] FAIL ovf_set status=%h expected=000d", statusData);
                end
            end
            if (c == 11) begin
                checks++;
                if (statusData !== 16'h0005) begin
                    failures++;
                    $display("[TB] FAIL ovf_clear status=%h expected=0005", statusData);
                end
            end
            if (c >= 2 && c - 2 < 9 * FRAME) begin
                checks++;
                if (tx !== frame_bit(8'h50 + 8'((c - 2) / FRAME), ((c - 2) % FRAME) / CPB)) begin
                    failures++;
                    $display("[TB] FAIL ovf_tx s=%0d got=%b expected=%b", c - 2, tx,
                             frame_bit(8'h50 + 8'((c - 2) / FRAME), ((c - 2) % FRAME) / CPB));
                end
            end
            if (c - 2 == 9 * FRAME) begin
                checks++;
                if (busy !== 1'b0 || tx !== 1'b1 || statusData !== 16'h0002) begin
                    failures++;
                    $display("[TB] FAIL ovf_done busy=%b tx=%b status=%h expected 0/1/0002", busy, tx, statusData);
                end
            end
            if (c < 10)       drive(1'b1, 16'hFF00, {8'hEE, 8'h50 + 8'(c)});
            else if (c == 10) drive(1'b1, 16'hFF02, 16'h0001);
            else              drive(1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
        end
    endtask

    // Stores elsewhere, reads of DATA_ADDR and a status store with bit0=0
    // must leave the FIFO empty and the line idle.
    task automatic test_ignored();
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin
                checks++;
                if (tx !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL ignored c=%0d tx=%b busy=%b expected 1/0", c, tx, busy);
                end
            end
            case (c % 3)
                0:       drive(1'b1, 16'hFF04, 16'h00FF);
                1:       drive(1'b0, 16'hFF00, 16'h0055);
                default: drive(1'b1, 16'hFF02, 16'h0000);
            endcase
            @(negedge clk);
        end
        drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        checks++;
        if (statusData !== 16'h0002) begin
            failures++;
            $display("[TB] FAIL ignored_status got=%h expected=0002", statusData);
        end
    endtask

    // Reset during data bit 3 of the first of three bytes must abort the
    // frame and discard the two queued bytes.
    task automatic test_reset_midframe();
        logic [7:0] bytes [3];
        int         abort_s;
        bytes[0] = 8'hC8;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        abort_s  = CPB + 3 * CPB + 1;
        for (int c = 0; c <= abort_s + 3; c++) begin
            if (c - 2 == abort_s) begin
                checks++;
                if (tx !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL mid_bit3 got=%b expected=1", tx);
                end
            end
            if (c - 2 == abort_s + 1) begin
                checks++;
                if (tx !== 1'b1 || statusData !== 16'h0002 || busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL mid_abort tx=%b status=%h busy=%b expected 1/0002/0", tx, statusData, busy);
                end
            end
            rst = (c - 2 == abort_s) ? 1'b1 : 1'b0;
            if (c < 3) drive(1'b1, 16'hFF00, {8'h00, bytes[c]});
            else       drive(1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_after c=%0d tx=%b busy=%b expected 1/0", c, tx, busy);
            end
            @(negedge clk);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_ignored();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
